// File: rtl/frame_capture_sequencer.sv
// ---------------------------------------------------------------------------
// frame_capture_sequencer
//
// Host-commanded gate for the imager pixel stream. After an accepted start it
// passes whole frames downstream, optionally keeping one frame out of every
// skip_amount frames, until num_frames frames have been passed (or forever
// when num_frames is 0) or until an abort lands on a frame boundary.
// Partial frames are never emitted.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, abort        one-cycle host command pulses
//   num_frames          frames to pass (0 = continuous), latched on start
//   skip_amount         keep 1 of every N frames (0/1 = all), latched on start
//   dvi/dtypei/datai    input beat: valid, data type code, data
//   dvo/dtypeo/datao    output beat, one cycle behind the input; only dvo gated
//   busy                high from an accepted start until the sequence ends
//   done                one-cycle pulse when a sequence ends
//   aborted             last sequence ended by abort
//   frames_passed       frames passed in the current/last sequence (saturating)
// ---------------------------------------------------------------------------
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif

module frame_capture_sequencer #(
    parameter int DOWNSAMPLE_WIDTH = 16,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [COUNT_WIDTH-1:0]        num_frames,
    input  logic [DOWNSAMPLE_WIDTH-1:0]   skip_amount,
    input  logic                          dvi,
    input  logic [`DTYPE_WIDTH-1:0]       dtypei,
    input  logic [15:0]                   datai,
    output logic                          dvo,
    output logic [`DTYPE_WIDTH-1:0]       dtypeo,
    output logic [15:0]                   datao,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [COUNT_WIDTH-1:0]        frames_passed
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [COUNT_WIDTH-1:0]        num_frames_q, num_frames_d;
    logic [DOWNSAMPLE_WIDTH-1:0]   skip_amount_q, skip_amount_d;
    logic [DOWNSAMPLE_WIDTH-1:0]   skip_cnt_q, skip_cnt_d;
    logic [COUNT_WIDTH-1:0]        frames_passed_q, frames_passed_d;
    logic                          abort_pending_q, abort_pending_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          aborted_q, aborted_d;
    logic                          dvo_q, dvo_d;
    logic [`DTYPE_WIDTH-1:0]       dtypeo_q;
    logic [15:0]                   datao_q;

    logic                          fs_beat_s;
    logic                          fe_beat_s;
    logic                          complete_s;
    logic                          abort_req_s;
    logic                          stop_s;
    logic [DOWNSAMPLE_WIDTH:0]     skip_inc_s;
    logic [DOWNSAMPLE_WIDTH-1:0]   skip_next_s;
    logic                          pass_s;
    logic                          accept_start_s;
    logic                          eval_start_s;
    logic                          count_frame_s;
    logic                          end_seq_s;
    logic                          end_abort_s;

    assign fs_beat_s   = dvi && (dtypei == `DTYPE_FRAME_START);
    assign fe_beat_s   = dvi && (dtypei == `DTYPE_FRAME_END);

    // The frame that finishes on this beat is the last one requested.
    // Widened by one bit so a saturated count can never alias num_frames.
    assign complete_s  = (num_frames_q != {COUNT_WIDTH{1'b0}}) &&
                         (({1'b0, frames_passed_q} + {{COUNT_WIDTH{1'b0}}, 1'b1})
                          == {1'b0, num_frames_q});

    // An abort on the very frame-end beat counts as well as a pending one.
    assign abort_req_s = abort || abort_pending_q;
    assign stop_s      = abort_req_s || complete_s;

    // Modulo-skip_amount frame counter; skip_amount of 0 or 1 pins it at 0.
    assign skip_inc_s  = {1'b0, skip_cnt_q} + {{DOWNSAMPLE_WIDTH{1'b0}}, 1'b1};
    assign skip_next_s = (skip_inc_s >= {1'b0, skip_amount_q}) ?
                         {DOWNSAMPLE_WIDTH{1'b0}} : skip_inc_s[DOWNSAMPLE_WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-beat gating/event decisions
    always_comb begin
        state_d        = state_q;
        pass_s         = 1'b0;
        accept_start_s = 1'b0;
        eval_start_s   = 1'b0;
        count_frame_s  = 1'b0;
        end_seq_s      = 1'b0;
        end_abort_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_start_s = 1'b1;
                    state_d        = ST_WAIT;
                end else begin
                    state_d        = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    end_seq_s   = 1'b1;
                    end_abort_s = 1'b1;
                    state_d     = ST_IDLE;
                end else if (fs_beat_s) begin
                    eval_start_s = 1'b1;
                    if (skip_cnt_q == {DOWNSAMPLE_WIDTH{1'b0}}) begin
                        pass_s  = 1'b1;
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PASS: begin
                pass_s = 1'b1;
                if (fe_beat_s) begin
                    count_frame_s = 1'b1;
                    if (stop_s) begin
                        end_seq_s   = 1'b1;
                        end_abort_s = abort_req_s;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d     = ST_WAIT;
                    end
                end else if (fs_beat_s) begin
                    // Frame start without a frame end: the open frame is
                    // closed as passed and the new start is judged as in WAIT.
                    count_frame_s = 1'b1;
                    if (stop_s) begin
                        pass_s      = 1'b0;
                        end_seq_s   = 1'b1;
                        end_abort_s = abort_req_s;
                        state_d     = ST_IDLE;
                    end else begin
                        eval_start_s = 1'b1;
                        if (skip_cnt_q == {DOWNSAMPLE_WIDTH{1'b0}}) begin
                            state_d = ST_PASS;
                        end else begin
                            pass_s  = 1'b0;
                            state_d = ST_WAIT;
                        end
                    end
                end else begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter, configuration and status next-state
    always_comb begin
        num_frames_d    = num_frames_q;
        skip_amount_d   = skip_amount_q;
        skip_cnt_d      = skip_cnt_q;
        frames_passed_d = frames_passed_q;
        abort_pending_d = abort_pending_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        aborted_d       = aborted_q;
        dvo_d           = dvi & pass_s;
        if (accept_start_s) begin
            num_frames_d    = num_frames;
            skip_amount_d   = skip_amount;
            skip_cnt_d      = {DOWNSAMPLE_WIDTH{1'b0}};
            frames_passed_d = {COUNT_WIDTH{1'b0}};
            abort_pending_d = 1'b0;
            busy_d          = 1'b1;
            aborted_d       = 1'b0;
        end else begin
            if (eval_start_s) begin
                skip_cnt_d = skip_next_s;
            end else begin
                skip_cnt_d = skip_cnt_q;
            end
            if (count_frame_s && (frames_passed_q != {COUNT_WIDTH{1'b1}})) begin
                frames_passed_d = frames_passed_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                frames_passed_d = frames_passed_q;
            end
            if (end_seq_s) begin
                busy_d          = 1'b0;
                done_d          = 1'b1;
                aborted_d       = end_abort_s;
                abort_pending_d = 1'b0;
            end else if ((state_q == ST_PASS) && abort) begin
                abort_pending_d = 1'b1;
            end else begin
                abort_pending_d = abort_pending_q;
            end
        end
    end

    // Registered status, counters and one-cycle datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_frames_q    <= {COUNT_WIDTH{1'b0}};
            skip_amount_q   <= {DOWNSAMPLE_WIDTH{1'b0}};
            skip_cnt_q      <= {DOWNSAMPLE_WIDTH{1'b0}};
            frames_passed_q <= {COUNT_WIDTH{1'b0}};
            abort_pending_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            dvo_q           <= 1'b0;
            dtypeo_q        <= {`DTYPE_WIDTH{1'b0}};
            datao_q         <= 16'h0000;
        end else begin
            num_frames_q    <= num_frames_d;
            skip_amount_q   <= skip_amount_d;
            skip_cnt_q      <= skip_cnt_d;
            frames_passed_q <= frames_passed_d;
            abort_pending_q <= abort_pending_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            aborted_q       <= aborted_d;
            dvo_q           <= dvo_d;
            dtypeo_q        <= dtypei;
            datao_q         <= datai;
        end
    end

    assign dvo           = dvo_q;
    assign dtypeo        = dtypeo_q;
    assign datao         = datao_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign frames_passed = frames_passed_q;

endmodule

// File: doc/frame_capture_sequencer.md
Name: frame_capture_sequencer

Overview:
- Host-commanded gate for the imager pixel stream. It passes a programmed number of whole frames downstream, optionally keeping only every Nth frame, and blocks everything else.
- Sits between the imager stream source and the downstream frame consumers (USB/DRAM writers). It is the sequencing controller for frame-rate downsampling.
- It never emits a partial frame. Start, stop and abort all take effect only at frame boundaries.

Parameters:
- DOWNSAMPLE_WIDTH, 16, width of the skip_amount input and of the internal skip counter.
- COUNT_WIDTH, 16, width of num_frames and frames_passed.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a capture sequence. Honoured only when busy=0.
- abort  in  1  one-cycle pulse; stops the sequence at the next frame boundary.
- num_frames  in  COUNT_WIDTH  frames to pass; 0 means continuous until abort. Latched on an accepted start.
- skip_amount  in  DOWNSAMPLE_WIDTH  keep 1 frame of every skip_amount frames; 0 and 1 both mean keep every frame. Latched on an accepted start.
- dvi  in  1  input data valid.
- dtypei  in  `DTYPE_WIDTH  input data type (dtypes.v codes).
- datai  in  16  input data.
- dvo  out  1  output data valid.
- dtypeo  out  `DTYPE_WIDTH  output data type.
- datao  out  16  output data.
- busy  out  1  high from an accepted start until the sequence ends.
- done  out  1  one-cycle pulse when a sequence ends, by completion or by abort.
- aborted  out  1  set when a sequence ends by abort; cleared on the next accepted start.
- frames_passed  out  COUNT_WIDTH  frames passed in the current or last sequence; cleared on an accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters and latched configuration 0, abort_pending 0. Reset asserted mid-frame drops the rest of that frame; no output beats follow.
- Datapath:
  - One-cycle latency: dtypeo <= dtypei and datao <= datai every cycle, unconditionally.
  - Only dvo is gated: dvo <= dvi & pass, where pass is the gating decision for that input beat.
- State IDLE:
  - pass=0.
  - start: latch num_frames and skip_amount, clear frames_passed, skip_cnt and aborted, set busy, go to WAIT. Config latch, counter clears and state change all take effect on that same clock edge.
  - abort in IDLE is ignored.
- State WAIT (waiting for a frame start):
  - pass=0 except on a frame-start beat (dvi && dtypei==`DTYPE_FRAME_START).
  - On a frame-start beat with skip_cnt==0: pass this beat, go to PASS.
  - On a frame-start beat with skip_cnt!=0: drop the frame and stay in WAIT.
  - Skip counter on every frame-start beat: skip_cnt <= (skip_cnt+1 >= skip_amount) ? 0 : skip_cnt+1.
- State PASS:
  - pass=1.
  - On dvi && dtypei==`DTYPE_FRAME_END: pass the beat and increment frames_passed. Then:
    - if abort_pending, or (num_frames!=0 and frames_passed+1==num_frames): go to IDLE, pulse done next cycle, clear busy, set aborted if abort_pending;
    - otherwise go to WAIT.
  - A frame-start beat in PASS with no preceding frame end is a truncated frame:
    - count it as passed (frames_passed increments);
    - if that ends the sequence (same completion/abort test as above), drop the new frame-start beat and go to IDLE;
    - otherwise evaluate the new frame-start beat exactly as in WAIT, in the same cycle.
- Abort:
  - In WAIT: immediate; go to IDLE, pulse done, set aborted.
  - In PASS: set abort_pending; the current frame completes through its frame end.
  - An abort in the same cycle as a frame-end beat in PASS ends the sequence on that beat.
- Start while busy=1 is ignored; the latched configuration is unchanged.
- Start and abort in the same cycle while IDLE: start wins and abort is ignored.
- frames_passed saturates at all ones; it never wraps.
- done and busy fall/pulse on the same edge. busy=0 and done=1 are visible in the same cycle, one cycle after the terminating beat is registered.
- Input beats with dvi=0 never change state or counters.

Test Plan:
- num_frames=2, skip_amount=1, 4 back-to-back frames -> frames 0 and 1 appear on dvo with 1-cycle latency; done pulses once after frame 1's FRAME_END; frames_passed=2; busy=0; no dvo for frames 2 and 3.
- num_frames=3, skip_amount=3, 9 frames -> frames 0, 3 and 6 passed; frames_passed=3; done after frame 6; skip_amount=0 run passes every frame.
- Start mid-frame (mid-line data beats present) -> no dvo until the next FRAME_START; that next frame is passed complete.
- num_frames=0, abort issued mid-frame 5 -> frame 5 passed in full through its FRAME_END; done=1 and aborted=1; frames_passed=6; abort issued in WAIT ends the sequence the next cycle with frames_passed unchanged.
- Truncated frame (second FRAME_START with no FRAME_END), num_frames=1 -> frames_passed=1, second FRAME_START beat dropped (dvo=0), done pulses.
- Reset asserted mid-PASS, and start pulsed while busy -> after reset all outputs 0 and no further dvo; start while busy leaves num_frames/skip_amount unchanged (verify by completion count).
